// File: rtl/projectile_pool_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : projectile_pkg
// Brief  : Shared types and default widths for the projectile pool.
// Rev    : 1.0
// ============================================================================
package projectile_pkg;

    localparam int DEF_MAX_PROJ = 16;
    localparam int DEF_X_W      = 12;
    localparam int DEF_Y_W      = 11;
    localparam int DEF_SPEED    = 4;
    localparam int DEF_PROJ_W   = 2;
    localparam int DEF_PROJ_H   = 6;
    localparam int DEF_COOLDOWN = 8;

    typedef struct packed {
        logic               valid;
        logic [DEF_X_W-1:0] x;
        logic [DEF_Y_W-1:0] y;
    } proj_slot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        MOVE  = 2'd2
    } proj_state_e;

endpackage
`default_nettype wire

// File: rtl/projectile_pool_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : projectile_pool_if
// Brief  : Fire/frame/pixel bundle of the projectile pool; kill lines exist
//          only when PROJECTILE_KILL_EN is defined.
// Rev    : 1.0
// ============================================================================
interface projectile_pool_if
    import projectile_pkg::*;
#(
    parameter int MAX_PROJ = DEF_MAX_PROJ,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W
);
    localparam int SLOT_W = $clog2(MAX_PROJ);

    logic              fire_n;
    logic [X_W-1:0]    spawn_x;
    logic [Y_W-1:0]    spawn_y;
    logic              frame_tick;
    logic [X_W-1:0]    display_col;
    logic [Y_W-1:0]    display_row;
    logic              pixel_hit;
    logic [SLOT_W-1:0] pixel_slot;
    logic              busy;
    logic [SLOT_W:0]   live_count;
    logic              overflow;
`ifdef PROJECTILE_KILL_EN
    logic              kill;
    logic [SLOT_W-1:0] kill_slot;

    modport master (
        output fire_n, spawn_x, spawn_y, frame_tick, display_col, display_row,
               kill, kill_slot,
        input  pixel_hit, pixel_slot, busy, live_count, overflow
    );
    modport slave (
        input  fire_n, spawn_x, spawn_y, frame_tick, display_col, display_row,
               kill, kill_slot,
        output pixel_hit, pixel_slot, busy, live_count, overflow
    );
`else
    modport master (
        output fire_n, spawn_x, spawn_y, frame_tick, display_col, display_row,
        input  pixel_hit, pixel_slot, busy, live_count, overflow
    );
    modport slave (
        input  fire_n, spawn_x, spawn_y, frame_tick, display_col, display_row,
        output pixel_hit, pixel_slot, busy, live_count, overflow
    );
`endif

endinterface
`default_nettype wire

// File: rtl/projectile_pool_first_free.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : proj_first_free
// Brief  : Lowest-index-wins priority encoder over an N-bit request vector.
// Rev    : 1.0
// ============================================================================
module proj_first_free #(
    parameter  int N  = 16,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec_i,
    output logic          found_o,
    output logic [IW-1:0] index_o
);

    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                found_o = 1'b1;
                index_o = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/projectile_pool.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : projectile_pool
// Brief  : Slot-based projectile manager: spawn on fire, per-frame move, pixel
//          hit test. Optional macro PROJECTILE_KILL_EN adds slot kill input.
// Rev    : 1.0
// ============================================================================
module projectile_pool
    import projectile_pkg::*;
#(
    parameter int MAX_PROJ = DEF_MAX_PROJ,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int SPEED    = DEF_SPEED,
    parameter int PROJ_W   = DEF_PROJ_W,
    parameter int PROJ_H   = DEF_PROJ_H,
    parameter int COOLDOWN = DEF_COOLDOWN
) (
    input  wire                 clock,
    input  wire                 reset,
    projectile_pool_if.slave    bus
);

    localparam int SLOT_W = $clog2(MAX_PROJ);
    localparam int CD_W   = $clog2(COOLDOWN + 2);

    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } slot_t;

    proj_state_e       state_q, state_d;
    logic [SLOT_W-1:0] idx_q, idx_d;
    slot_t             slots_q [MAX_PROJ];
    slot_t             slots_d [MAX_PROJ];
    logic              fire_prev_q;
    logic              fire_pend_q, fire_pend_d;
    logic [X_W-1:0]    pend_x_q, pend_x_d;
    logic [Y_W-1:0]    pend_y_q, pend_y_d;
    logic [CD_W-1:0]   cd_q, cd_d;
    logic [SLOT_W:0]   live_q, live_d;
    logic              hit_q;
    logic [SLOT_W-1:0] hit_slot_q;

    logic [MAX_PROJ-1:0] free_vec, cover_vec;
    logic                free_found, cover_found;
    logic [SLOT_W-1:0]   free_idx, cover_idx;
    logic                fire_edge, spawning;

    assign fire_edge = fire_prev_q & ~bus.fire_n;
    assign spawning  = (state_q == SPAWN) && fire_pend_q && free_found;

    // One spare bit on each bound so a box touching the screen edge cannot wrap
    generate
        for (genvar gi = 0; gi < MAX_PROJ; gi++) begin : g_slot
            assign free_vec[gi]  = ~slots_q[gi].valid;
            assign cover_vec[gi] = slots_q[gi].valid
                && ({1'b0, bus.display_col} >= {1'b0, slots_q[gi].x})
                && ({1'b0, bus.display_col} <  ({1'b0, slots_q[gi].x} + (X_W+1)'(PROJ_W)))
                && ({1'b0, bus.display_row} >= {1'b0, slots_q[gi].y})
                && ({1'b0, bus.display_row} <  ({1'b0, slots_q[gi].y} + (Y_W+1)'(PROJ_H)));
        end
    endgenerate

    proj_first_free #(.N(MAX_PROJ)) u_free (
        .vec_i   (free_vec),
        .found_o (free_found),
        .index_o (free_idx)
    );

    proj_first_free #(.N(MAX_PROJ)) u_cover (
        .vec_i   (cover_vec),
        .found_o (cover_found),
        .index_o (cover_idx)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        slots_d     = slots_q;
        fire_pend_d = fire_pend_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        cd_d        = cd_q;

        if (bus.frame_tick && (cd_q != '0)) begin
            cd_d = cd_q - CD_W'(1);
        end
`ifdef PROJECTILE_KILL_EN
        // Applied first: a same-cycle spawn overwrites it, a same-cycle move sees it
        if (bus.kill && (int'(bus.kill_slot) < MAX_PROJ)) begin
            slots_d[bus.kill_slot].valid = 1'b0;
        end
`endif
        case (state_q)
            IDLE: begin
                if (bus.frame_tick) begin
                    state_d = SPAWN;
                end
            end
            SPAWN: begin
                if (spawning) begin
                    slots_d[free_idx] = '{valid: 1'b1, x: pend_x_q, y: pend_y_q};
                    cd_d              = CD_W'(COOLDOWN);
                end
                fire_pend_d = 1'b0;
                idx_d       = '0;
                state_d     = MOVE;
            end
            MOVE: begin
                if (slots_d[idx_q].valid) begin
                    if (slots_q[idx_q].y < Y_W'(SPEED)) begin
                        slots_d[idx_q].valid = 1'b0;
                    end else begin
                        slots_d[idx_q].y = slots_q[idx_q].y - Y_W'(SPEED);
                    end
                end
                idx_d = idx_q + SLOT_W'(1);
                if (idx_q == SLOT_W'(MAX_PROJ - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Evaluated after the SPAWN clear so a press landing in SPAWN is kept
        if (fire_edge && (cd_q == '0) && !(spawning && (COOLDOWN != 0))) begin
            fire_pend_d = 1'b1;
            pend_x_d    = bus.spawn_x;
            pend_y_d    = bus.spawn_y;
        end
    end

    always_comb begin
        live_d = '0;
        for (int i = 0; i < MAX_PROJ; i++) begin
            live_d = live_d + {{SLOT_W{1'b0}}, slots_q[i].valid};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            fire_prev_q <= 1'b1;
            fire_pend_q <= 1'b0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            cd_q        <= '0;
            live_q      <= '0;
            hit_q       <= 1'b0;
            hit_slot_q  <= '0;
            for (int i = 0; i < MAX_PROJ; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fire_prev_q <= bus.fire_n;
            fire_pend_q <= fire_pend_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            cd_q        <= cd_d;
            live_q      <= live_d;
            hit_q       <= cover_found;
            hit_slot_q  <= cover_idx;
            for (int i = 0; i < MAX_PROJ; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    assign bus.pixel_hit  = hit_q;
    assign bus.pixel_slot = hit_slot_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.live_count = live_q;
    assign bus.overflow   = (state_q == SPAWN) && fire_pend_q && !free_found;

endmodule
`default_nettype wire

// File: tb/tb_projectile_pool.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_projectile_pool
// Brief  : Randomised scoreboard bench for projectile_pool against a
//          frame-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_projectile_pool;

    localparam int MP  = 16;
    localparam int XW  = 12;
    localparam int YW  = 11;
    localparam int SPD = 4;
    localparam int PW  = 2;
    localparam int PH  = 6;
    localparam int CD  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    projectile_pool_if #(.MAX_PROJ(MP), .X_W(XW), .Y_W(YW)) bus();

    projectile_pool #(
        .MAX_PROJ(MP), .X_W(XW), .Y_W(YW), .SPEED(SPD),
        .PROJ_W(PW), .PROJ_H(PH), .COOLDOWN(CD)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    typedef struct { bit hit; int slot; } pix_t;

    // Reference model: whole-frame state
    bit m_v [MP];
    int m_x [MP];
    int m_y [MP];
    int m_cd;
    bit m_pend;
    int m_px, m_py;
    bit m_fire;

    pix_t pix_q [$];
    int   lc_q  [$];
    int   busy_q[$];
    int   ovf_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    bit qv = 0, qv_d = 0, lcv = 0, rchk = 0, dchk = 0;

    always @(posedge clk) qv_d <= qv;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sole owner of the counters
    initial begin : monitor
        bit busy_prev;
        int run;
        pix_t e;
        busy_prev = 0;
        run = 0;
        forever begin
            @(negedge clk);
            if (rchk) begin
                check("rst_pixel_hit",  64'(bus.pixel_hit),  0);
                check("rst_pixel_slot", 64'(bus.pixel_slot), 0);
                check("rst_busy",       64'(bus.busy),       0);
                check("rst_live_count", 64'(bus.live_count), 0);
                check("rst_overflow",   64'(bus.overflow),   0);
            end
            if (dchk) begin
                check("pix_queue_left",  64'(pix_q.size()),  0);
                check("busy_queue_left", 64'(busy_q.size()), 0);
                check("ovf_queue_left",  64'(ovf_q.size()),  0);
            end
            if (!rst_n) begin
                busy_prev = 0;
                run = 0;
            end else begin
                if (bus.busy && !busy_prev) begin
                    if (ovf_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL busy_rise: got unexpected frame start required none");
                    end else begin
                        check("overflow", 64'(bus.overflow), 64'(ovf_q.pop_front()));
                    end
                end else if (bus.overflow === 1'b1) begin
                    n_tests++; n_fail++;
                    $display("FAIL overflow_stray: got 1 outside SPAWN required 0");
                end
                if (bus.busy) run++;
                if (busy_prev && !bus.busy) begin
                    if (busy_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL busy_fall: got unexpected busy end required none");
                    end else begin
                        check("busy_cycles", 64'(run), 64'(busy_q.pop_front()));
                    end
                    run = 0;
                end
                busy_prev = bus.busy;
                if (qv_d) begin
                    if (pix_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL pix_queue: got empty queue required an entry");
                    end else begin
                        e = pix_q.pop_front();
                        check("pixel_hit", 64'(bus.pixel_hit), 64'(e.hit));
                        if (e.hit) check("pixel_slot", 64'(bus.pixel_slot), 64'(e.slot));
                    end
                end
                if (lcv && lc_q.size() != 0) begin
                    check("live_count", 64'(bus.live_count), 64'(lc_q.pop_front()));
                    check("busy_idle",  64'(bus.busy), 0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        for (int i = 0; i < MP; i++) begin
            m_v[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_cd = 0; m_pend = 0; m_px = 0; m_py = 0; m_fire = 1;
    endtask

    function automatic int model_live();
        int n = 0;
        for (int i = 0; i < MP; i++) n += int'(m_v[i]);
        return n;
    endfunction

    function automatic pix_t model_pix(int c, int r);
        pix_t p;
        p.hit = 0; p.slot = 0;
        for (int i = 0; i < MP; i++) begin
            if (m_v[i] && c >= m_x[i] && c < m_x[i] + PW && r >= m_y[i] && r < m_y[i] + PH) begin
                p.hit = 1; p.slot = i;
                break;
            end
        end
        return p;
    endfunction

    // One whole frame update as seen from the frame tick
    task automatic model_frame(int kslot);
        int f;
        bit ov;
        ov = 0;
        if (m_cd > 0) m_cd--;
        if (m_pend) begin
            f = -1;
            for (int i = 0; i < MP; i++) if (!m_v[i] && f < 0) f = i;
            if (f < 0) ov = 1;
            else begin
                m_v[f] = 1; m_x[f] = m_px; m_y[f] = m_py; m_cd = CD;
            end
            m_pend = 0;
        end
        ovf_q.push_back(int'(ov));
        busy_q.push_back(MP + 1);
        for (int i = 0; i < MP; i++) begin
            if (i == kslot) m_v[i] = 0;
            else if (m_v[i]) begin
                if (m_y[i] < SPD) m_v[i] = 0;
                else m_y[i] -= SPD;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.frame_tick = 0;
        qv = 0; lcv = 0; rchk = 0; dchk = 0;
`ifdef PROJECTILE_KILL_EN
        bus.kill = 0;
`endif
    endtask

    task automatic set_fire(bit f, int sx, int sy);
        if (m_fire && !f && m_cd == 0) begin
            m_pend = 1; m_px = sx; m_py = sy;
        end
        m_fire = f;
        bus.fire_n  = f;
        bus.spawn_x = XW'(sx);
        bus.spawn_y = YW'(sy);
    endtask

    task automatic press(int sx, int sy);
        step(); set_fire(0, sx, sy);
        step(); set_fire(1, sx, sy);
    endtask

    task automatic do_frame(bit rnd_fire, int kslot);
        step();
        bus.frame_tick = 1;
        model_frame(kslot);
        step();
        for (int k = 0; k < MP; k++) begin
            step();
`ifdef PROJECTILE_KILL_EN
            if (k == kslot) begin
                bus.kill = 1; bus.kill_slot = 4'(k);
            end
`endif
            if (rnd_fire && k == 7 && $urandom_range(1) == 1) begin
                bus.frame_tick = 1;
                if (m_cd > 0) m_cd--;
            end else if (rnd_fire && $urandom_range(3) == 0) begin
                set_fire(!m_fire, int'($urandom_range(0, 4095)), int'($urandom_range(0, 2047)));
            end
        end
        step();
        step();
        lcv = 1;
        lc_q.push_back(model_live());
    endtask

    task automatic query(int c, int r);
        step();
        bus.display_col = XW'(c);
        bus.display_row = YW'(r);
        qv = 1;
        pix_q.push_back(model_pix(c, r));
    endtask

    task automatic rand_queries(int n);
        int s, c, r;
        for (int q = 0; q < n; q++) begin
            s = int'($urandom_range(0, MP - 1));
            if (m_v[s] && $urandom_range(3) != 0) begin
                c = m_x[s] - 1 + int'($urandom_range(0, PW + 1));
                r = m_y[s] - 1 + int'($urandom_range(0, PH + 1));
            end else begin
                c = int'($urandom_range(0, 4095));
                r = int'($urandom_range(0, 2047));
            end
            if (c < 0) c = 0;
            if (c > 4095) c = 4095;
            if (r < 0) r = 0;
            if (r > 2047) r = 2047;
            query(c, r);
        end
        step();
    endtask

    initial begin
        int ks, sx;
        bus.fire_n = 1; bus.spawn_x = '0; bus.spawn_y = '0; bus.frame_tick = 0;
        bus.display_col = '0; bus.display_row = '0;
`ifdef PROJECTILE_KILL_EN
        bus.kill = 0; bus.kill_slot = '0;
`endif
        model_reset();
        step(); step();
        rchk = 1;
        step();
        rst_n = 1;

        // Single shot at (100,400): ends at y=396 in slot 0
        press(100, 400);
        do_frame(0, -1);
        query(100, 396); query(102, 396); query(101, 401); query(101, 402);
        step();

        // Low projectile: spawned at 7, reaches 3, then leaves without wrapping
        repeat (8) do_frame(0, -1);
        press(50, 7);
        do_frame(0, -1);
        query(50, 3);
        do_frame(0, -1);
        query(50, 3); query(50, 2047);
        step();

        // Fire every frame: cooldown gating, pool fills, then overflow
        for (int f = 0; f < 170; f++) begin
            press(int'($urandom_range(0, 4095)), 2040);
            do_frame(0, -1);
            if (f % 10 == 0) rand_queries(4);
        end

        // Asynchronous reset in the middle of MOVE
        step();
        bus.frame_tick = 1;
        model_frame(-1);
        step();
        repeat (6) step();
        rst_n = 0;
        rchk = 1;
        model_reset();
        busy_q.delete();
        bus.fire_n = 1;
        step();
        rst_n = 1;
        do_frame(0, -1);
        rand_queries(3);

        // Random traffic including right-edge spawns and fire during busy
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(1) == 1) begin
                sx = ($urandom_range(3) == 0) ? 4095 : int'($urandom_range(0, 4095));
                press(sx, int'($urandom_range(0, 2047)));
            end
            ks = -1;
`ifdef PROJECTILE_KILL_EN
            if ($urandom_range(1) == 1) ks = int'($urandom_range(0, MP - 1));
`endif
            do_frame(1, ks);
            rand_queries(6);
        end

        step();
        dchk = 1;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
